// File: rtl/seq_run_pkg.sv
// Shared state encoding and default widths for the run detector.
package seq_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN0 = 2'd1,
    ST_RUN1 = 2'd2
  } state_t;

  localparam int unsigned DEF_RL_W  = 4;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] base;
  logic [W-1:0] nxt;
  logic         base_sat;

  // A clear on the same edge as an increment acts first, so the increment lands on zero.
  always_comb begin
    base     = clr ? '0 : cnt;
    base_sat = clr ? 1'b0 : sat;
    nxt      = base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (base != '1)) begin
      cnt <= nxt;
      sat <= base_sat || (nxt == '1);
    end else begin
      cnt <= base;
      sat <= base_sat;
    end
  end

endmodule

// File: rtl/seq_run_detector.sv
// Programmable-length run detector (N equal serial bits) with episode counter.
// Optional bit history outputs enabled by defining SEQ_RUN_HIST_EN.
module seq_run_detector
  import seq_run_pkg::*;
#(
  parameter int unsigned RL_W  = DEF_RL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             din,
  input  logic             flush,
  input  logic [RL_W-1:0]  run_len,
  input  logic             clr_cnt,
  output logic             det,
  output logic             det_zero,
  output logic             det_one,
  output logic [RL_W-1:0]  run_cnt,
  output logic [CNT_W-1:0] hit_cnt,
`ifdef SEQ_RUN_HIST_EN
  output logic [7:0]       hist,
  output logic [7:0]       hist_at_det,
`endif
  output logic             cnt_sat
);

  state_t          state_q, state_d;
  logic [RL_W-1:0] n_q, n_d;
  logic [RL_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            dz_q, dz_d;
  logic            d1_q, d1_d;
  logic            hit;
  logic            episode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      d1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = (state_q == ST_IDLE) ? run_len : n_q;
    cnt_inc = (cnt_q >= n_q) ? n_q : cnt_q + 1'b1;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bit_vld) begin
      unique case (state_q)
        ST_IDLE: begin
          if (n_q != '0) begin
            state_d = din ? ST_RUN1 : ST_RUN0;
            cnt_d   = RL_W'(1);
          end
        end
        ST_RUN0: begin
          if (din) begin
            state_d = ST_RUN1;
            cnt_d   = RL_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN1: begin
          if (!din) begin
            state_d = ST_RUN0;
            cnt_d   = RL_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Detect flags are decoded from next-state values and registered, so they
    // equal the Moore decode of the registered state while letting the episode
    // counter see a rise or polarity flip on the same edge.
    hit     = (state_d != ST_IDLE) && (cnt_d == n_d);
    dz_d    = hit && (state_d == ST_RUN0);
    d1_d    = hit && (state_d == ST_RUN1);
    episode = (dz_d && !dz_q) || (d1_d && !d1_q);
  end

  assign det      = dz_q | d1_q;
  assign det_zero = dz_q;
  assign det_one  = d1_q;
  assign run_cnt  = cnt_q;

  sat_counter #(
    .W(CNT_W)
  ) u_hits (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (episode),
    .clr  (clr_cnt),
    .cnt  (hit_cnt),
    .sat  (cnt_sat)
  );

`ifdef SEQ_RUN_HIST_EN
  logic [7:0] hist_q, hat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      hat_q  <= '0;
    end else begin
      if (bit_vld) hist_q <= {hist_q[6:0], din};
      if (episode) hat_q <= {hist_q[6:0], din};
    end
  end

  assign hist        = hist_q;
  assign hist_at_det = hat_q;
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Scoreboard bench for seq_run_detector (RL_W=4, CNT_W=2) using directed vectors.
module tb_seq_run_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_vld = 1'b0;
  logic       din = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] run_len = 4'd4;
  logic       clr_cnt = 1'b0;
  logic       det, det_zero, det_one, cnt_sat;
  logic [3:0] run_cnt;
  logic [1:0] hit_cnt;
`ifdef SEQ_RUN_HIST_EN
  logic [7:0] hist, hist_at_det;
`endif

  seq_run_detector #(
    .RL_W (4),
    .CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_vld    (bit_vld),
    .din        (din),
    .flush      (flush),
    .run_len    (run_len),
    .clr_cnt    (clr_cnt),
    .det        (det),
    .det_zero   (det_zero),
    .det_one    (det_one),
    .run_cnt    (run_cnt),
    .hit_cnt    (hit_cnt),
`ifdef SEQ_RUN_HIST_EN
    .hist       (hist),
    .hist_at_det(hist_at_det),
`endif
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        ent;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [9:0]  act;

  always @(posedge clk) cyc++;

  // Each entry targets the cycle after the edge that should produce it.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      ent = sbq.pop_front();
      act = {det, det_zero, det_one, run_cnt, hit_cnt, cnt_sat};
      n_checks++;
      if (act !== ent.exp) begin
        n_fail++;
        $display("FAIL %s: {det,dz,d1,run_cnt,hit_cnt,sat} got %b required %b",
                 ent.name, act, ent.exp);
      end
    end
  end

  function automatic logic [9:0] ex(input logic d, input logic dz, input logic d1,
                                    input logic [3:0] rc, input logic [1:0] hc,
                                    input logic s);
    return {d, dz, d1, rc, hc, s};
  endfunction

  task automatic step(input string nm, input logic r, input logic v, input logic d,
                      input logic f, input logic c, input logic [3:0] rl,
                      input logic [9:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n   = r;
    bit_vld = v;
    din     = d;
    flush   = f;
    clr_cnt = c;
    run_len = rl;
    x.cyc   = cyc + 1;
    x.exp   = e;
    x.name  = nm;
    sbq.push_back(x);
  endtask

  initial begin
    //    name        rst v  d  fl cl rl     det dz d1 rc  hc sat
    step("reset",     0, 0, 0, 0, 0, 4, ex(0, 0, 0, 0, 0, 0));
    step("idle_load", 1, 0, 0, 0, 0, 4, ex(0, 0, 0, 0, 0, 0));
    step("ones_b1",   1, 1, 1, 0, 0, 4, ex(0, 0, 0, 1, 0, 0));
    step("ones_b2",   1, 1, 1, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("ones_b3",   1, 1, 1, 0, 0, 4, ex(0, 0, 0, 3, 0, 0));
    step("ones_b4",   1, 1, 1, 0, 0, 4, ex(1, 0, 1, 4, 1, 0));
    step("ones_b5",   1, 1, 1, 0, 0, 4, ex(1, 0, 1, 4, 1, 0));
    step("flush_clr", 1, 0, 0, 1, 1, 4, ex(0, 0, 0, 0, 0, 0));

    step("mix_b1",    1, 1, 0, 0, 0, 4, ex(0, 0, 0, 1, 0, 0));
    step("mix_b2",    1, 1, 0, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("mix_b3",    1, 1, 0, 0, 0, 4, ex(0, 0, 0, 3, 0, 0));
    step("mix_b4",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 1, 0, 0));
    step("mix_b5",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("mix_b6",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 3, 0, 0));
    step("mix_b7",    1, 1, 1, 0, 0, 4, ex(1, 0, 1, 4, 1, 0));
    step("mix_b8",    1, 1, 0, 0, 0, 4, ex(0, 0, 0, 1, 1, 0));
    step("mix_b9",    1, 1, 0, 0, 0, 4, ex(0, 0, 0, 2, 1, 0));
    step("mix_b10",   1, 1, 0, 0, 0, 4, ex(0, 0, 0, 3, 1, 0));
    step("mix_b11",   1, 1, 0, 0, 0, 4, ex(1, 1, 0, 4, 2, 0));
    step("flush_clr2",1, 0, 0, 1, 1, 4, ex(0, 0, 0, 0, 0, 0));

    step("gap_b1",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 1, 0, 0));
    step("gap_b2",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("gap_hold",  1, 0, 0, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("gap_b3",    1, 1, 1, 0, 0, 4, ex(0, 0, 0, 3, 0, 0));
    step("gap_b4",    1, 1, 1, 0, 0, 4, ex(1, 0, 1, 4, 1, 0));
    step("flush_clr3",1, 0, 0, 1, 1, 4, ex(0, 0, 0, 0, 0, 0));

    step("fl_b1",     1, 1, 1, 0, 0, 4, ex(0, 0, 0, 1, 0, 0));
    step("fl_b2",     1, 1, 1, 0, 0, 4, ex(0, 0, 0, 2, 0, 0));
    step("fl_b3",     1, 1, 1, 0, 0, 4, ex(0, 0, 0, 3, 0, 0));
    step("fl_vs_vld", 1, 1, 1, 1, 0, 2, ex(0, 0, 0, 0, 0, 0));
    step("n2_load",   1, 0, 0, 0, 0, 2, ex(0, 0, 0, 0, 0, 0));
    step("n2_b1",     1, 1, 1, 0, 0, 2, ex(0, 0, 0, 1, 0, 0));
    step("n2_b2",     1, 1, 1, 0, 0, 2, ex(1, 0, 1, 2, 1, 0));

    step("flush_clr4",1, 0, 0, 1, 1, 1, ex(0, 0, 0, 0, 0, 0));
    step("n1_load",   1, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));
    step("n1_b1",     1, 1, 0, 0, 0, 1, ex(1, 1, 0, 1, 1, 0));
    step("n1_b2",     1, 1, 1, 0, 0, 1, ex(1, 0, 1, 1, 2, 0));
    step("n1_b3_sat", 1, 1, 0, 0, 0, 1, ex(1, 1, 0, 1, 3, 1));
    step("n1_b4",     1, 1, 1, 0, 0, 1, ex(1, 0, 1, 1, 3, 1));
    step("n1_b5",     1, 1, 0, 0, 0, 1, ex(1, 1, 0, 1, 3, 1));
    step("clr_only",  1, 0, 0, 0, 1, 1, ex(1, 1, 0, 1, 0, 0));
    step("clr_and_ep",1, 1, 1, 0, 1, 1, ex(1, 0, 1, 1, 1, 0));

    step("reset_det", 0, 1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("n0_load",   1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    for (int unsigned i = 0; i < 4; i++)
      step("n0_ones",  1, 1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("n0_zero",   1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    bit_vld = 1'b0;
    for (int unsigned i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    #5;
    while (sbq.size() > 0) begin
      ent = sbq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: no check before timeout, required %b", ent.name, ent.exp);
    end

    n_checks++;
    if (det !== 1'b0) begin
      n_fail++;
      $display("FAIL n0_final_det: got %b required 0", det);
    end
    n_checks++;
    if (run_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL n0_final_run_cnt: got %0d required 0", run_cnt);
    end
    n_checks++;
    if (hit_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL n0_final_hit_cnt: got %0d required 0", hit_cnt);
    end
    n_checks++;
    if (cnt_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL n0_final_cnt_sat: got %b required 0", cnt_sat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
